// File: rtl/ctrl_port.sv
// ctrl_port: NES controller port responder; strobe write to 0x4016 latches both pads,
// reads of 0x4016/0x4017 shift out one button bit per access.
module ctrl_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PORT0_ADDR = 16'h4016,
  parameter logic [ADDR_WIDTH-1:0] PORT1_ADDR = 16'h4017
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  din,
  output logic [REG_WIDTH-1:0]  dout,
  output logic                  sel,
  input  logic [7:0]            buttons0,
  input  logic [7:0]            buttons1,
  output logic                  strobe_out
);
  logic strobe_q, strobe_d;
  logic [7:0] sr0_q, sr0_d, sr1_q, sr1_d;
  logic [REG_WIDTH-1:0] dout_q, dout_d;
  logic is_p0, is_p1, wr, rd, bit_n;

  assign is_p0 = addr == PORT0_ADDR;
  assign is_p1 = addr == PORT1_ADDR;
  assign sel = is_p0 | is_p1;
  assign dout = dout_q;
  assign strobe_out = strobe_q;

  // a simultaneous write suppresses the read and its shift side effect
  always_comb begin
    wr = we & is_p0;
    rd = re & ~we & sel;
    bit_n = strobe_q ? (is_p1 ? buttons1[0] : buttons0[0]) : (is_p1 ? sr1_q[0] : sr0_q[0]);
    strobe_d = wr ? din[0] : strobe_q;
    sr0_d = strobe_q ? buttons0 : (rd & is_p0) ? {1'b1, sr0_q[7:1]} : sr0_q;
    sr1_d = strobe_q ? buttons1 : (rd & is_p1) ? {1'b1, sr1_q[7:1]} : sr1_q;
    dout_d = rd ? REG_WIDTH'({7'b0100000, bit_n}) : dout_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      sr0_q <= 8'h00;
      sr1_q <= 8'h00;
      dout_q <= '0;
    end else begin
      strobe_q <= strobe_d;
      sr0_q <= sr0_d;
      sr1_q <= sr1_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_ctrl_port.sv
// tb_ctrl_port: directed test of ctrl_port with hand-computed read values.
module tb_ctrl_port;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic we = 1'b0, re = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0] din = 8'h00, dout;
  logic sel, strobe_out;
  logic [7:0] buttons0 = 8'h00, buttons1 = 8'h00;
  int checks = 0, failures = 0;

  ctrl_port dut (
    .clk(clk), .reset_n(reset_n), .we(we), .re(re), .addr(addr), .din(din),
    .dout(dout), .sel(sel), .buttons0(buttons0), .buttons1(buttons1), .strobe_out(strobe_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; din = d;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    cyc(1'b0, 1'b1, a, 8'h00);
    chk(tag, dout, exp);
  endtask

  task automatic latch();
    cyc(1'b1, 1'b0, 16'h4016, 8'h01);
    cyc(1'b1, 1'b0, 16'h4016, 8'h00);
  endtask

  initial begin
    logic [7:0] a5_exp [10] = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41, 8'h41, 8'h41};
    // reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we = 1'($urandom); re = 1'($urandom); din = 8'($urandom);
      addr = (i % 2 == 0) ? 16'h4016 : 16'h4017;
      buttons0 = 8'($urandom); buttons1 = 8'($urandom);
    end
    #1;
    chk("reset_dout", dout, 8'h00);
    chk("reset_strobe", {7'b0, strobe_out}, 8'h00);
    chk("sel_in_reset", {7'b0, sel}, 8'h01);
    @(negedge clk);
    we = 1'b0; re = 1'b0; addr = 16'h0000; reset_n = 1'b1;
    rd("first_read", 16'h4016, 8'h40);

    // latch 0xA5 and shift out past the end
    buttons0 = 8'hA5;
    cyc(1'b1, 1'b0, 16'h4016, 8'h01);
    chk("strobe_set", {7'b0, strobe_out}, 8'h01);
    cyc(1'b1, 1'b0, 16'h4016, 8'h00);
    chk("strobe_clr", {7'b0, strobe_out}, 8'h00);
    buttons0 = 8'h00;
    for (int i = 0; i < 10; i++) rd($sformatf("a5_read%0d", i), 16'h4016, a5_exp[i]);

    // strobe held: reads follow live buttons, no shift
    cyc(1'b1, 1'b0, 16'h4016, 8'h01);
    buttons0 = 8'h01;
    rd("held_live1", 16'h4016, 8'h41);
    buttons0 = 8'h00;
    rd("held_live0", 16'h4016, 8'h40);
    buttons1 = 8'h01;
    rd("held_live_p1", 16'h4017, 8'h41);

    // independent ports
    buttons0 = 8'hFF; buttons1 = 8'h02;
    latch();
    buttons0 = 8'h00; buttons1 = 8'h00;
    rd("p1_read0", 16'h4017, 8'h40);
    rd("p1_read1", 16'h4017, 8'h41);
    rd("p0_read0", 16'h4016, 8'h41);
    rd("p1_read2", 16'h4017, 8'h40);

    // non-port reads and 0x4017 writes are ignored
    rd("nonport_hold", 16'h4018, 8'h40);
    cyc(1'b1, 1'b0, 16'h4017, 8'h01);
    chk("p1_write_ignored", {7'b0, strobe_out}, 8'h00);
    addr = 16'h4017; #1;
    chk("sel_p1", {7'b0, sel}, 8'h01);
    addr = 16'h4018; #1;
    chk("sel_other", {7'b0, sel}, 8'h00);

    // write beats read on the same cycle
    buttons0 = 8'h02;
    latch();
    buttons0 = 8'h00;
    rd("prio_pre", 16'h4016, 8'h40);
    cyc(1'b1, 1'b1, 16'h4016, 8'h00);
    chk("prio_hold", dout, 8'h40);
    chk("prio_strobe", {7'b0, strobe_out}, 8'h00);
    cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("idle_hold", dout, 8'h40);
    rd("prio_next", 16'h4016, 8'h41);
    rd("prio_next2", 16'h4016, 8'h40);

    // reset mid-sequence discards shift state
    buttons0 = 8'hFF;
    latch();
    buttons0 = 8'h00;
    for (int i = 0; i < 3; i++) rd($sformatf("ff_read%0d", i), 16'h4016, 8'h41);
    cyc(1'b1, 1'b0, 16'h4016, 8'h01);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_strobe", {7'b0, strobe_out}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    rd("post_rst_read", 16'h4016, 8'h40);
    chk("post_rst_strobe", {7'b0, strobe_out}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
